// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl
// Front end between the 12-key push-switch bank and the calculator core.
// Synchronises and debounces a one-hot key vector, accumulates decimal
// digits into a binary operand, issues one LCD write per accepted key over
// a req/ack handshake, and hands finished operands to the core on Enter.
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_IDLE     | waiting for a single valid key
// ST_DEBOUNCE | same key must stay stable for DEB_CYCLES cycles
// ST_EXEC     | one-cycle action for the accepted key
// ST_LCD_WR   | request held until the LCD writer acknowledges
// ST_RELEASE  | keys must read "none" for DEB_CYCLES cycles (no repeat)

module keypad_entry_ctrl #(
  parameter logic [15:0] DEB_CYCLES = 16'd50000,
  parameter int          MAX_DIGITS = 4,
  parameter int          BIN_W      = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [11:0]      i_sw_push,
  input  logic             lcd_ack,
  output logic             o_lcd_req,
  output logic             o_lcd_rs,
  output logic [7:0]       o_lcd_data,
  output logic [BIN_W-1:0] o_operand,
  output logic             o_operand_valid,
  output logic [3:0]       o_digit_cnt,
  output logic             o_overflow,
  output logic             o_busy
);

  localparam int         EXT_W = BIN_W + 4;
  localparam logic [3:0] MAX_D = 4'(MAX_DIGITS);
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CHR_SPACE = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_EXEC,
    ST_LCD_WR,
    ST_RELEASE
  } state_t;

  state_t             state_q, state_d;
  logic [11:0]        sync1_q, sync2_q;
  logic [11:0]        pat_q, pat_d;
  logic [15:0]        deb_cnt_q, deb_cnt_d;
  logic [BIN_W-1:0]   acc_q, acc_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [BIN_W-1:0]   operand_q, operand_d;
  logic               operand_valid_q, operand_valid_d;
  logic               overflow_q, overflow_d;
  logic               lcd_req_q, lcd_req_d;
  logic               lcd_rs_q, lcd_rs_d;
  logic [7:0]         lcd_data_q, lcd_data_d;

  logic               key_valid;
  logic [3:0]         key_digit;
  logic [15:0]        deb_inc;
  logic [EXT_W-1:0]   acc_ext;

  // Two-flop synchroniser on the raw switch vector
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= i_sw_push;
      sync2_q <= sync1_q;
    end
  end

  // Key qualification and decimal value of the latched digit key
  always_comb begin
    key_valid = $onehot(sync2_q);
    key_digit = 4'd0;
    for (int i = 2; i < 12; i++) begin
      if (pat_q[i]) key_digit = 4'(11 - i);
    end
    deb_inc = deb_cnt_q + 16'd1;
    acc_ext = ({4'd0, acc_q} * EXT_W'(10)) + EXT_W'(key_digit);
  end

  // Next-state and next-output computation for the sequencer
  always_comb begin
    state_d         = state_q;
    pat_d           = pat_q;
    deb_cnt_d       = deb_cnt_q;
    acc_d           = acc_q;
    cnt_d           = cnt_q;
    operand_d       = operand_q;
    operand_valid_d = 1'b0;
    overflow_d      = 1'b0;
    lcd_req_d       = lcd_req_q;
    lcd_rs_d        = lcd_rs_q;
    lcd_data_d      = lcd_data_q;

    case (state_q)
      ST_IDLE: begin
        if (key_valid) begin
          pat_d     = sync2_q;
          deb_cnt_d = '0;
          state_d   = ST_DEBOUNCE;
        end
      end

      ST_DEBOUNCE: begin
        if (!key_valid) begin
          state_d = ST_IDLE;
        end else if (sync2_q != pat_q) begin
          pat_d     = sync2_q;
          deb_cnt_d = '0;
        end else if (deb_inc >= DEB_CYCLES - 16'd1) begin
          // the IDLE cycle that latched the key counts as the first stable one
          state_d = ST_EXEC;
        end else begin
          deb_cnt_d = deb_inc;
        end
      end

      ST_EXEC: begin
        deb_cnt_d = '0;
        state_d   = ST_RELEASE;
        if (pat_q[0]) begin
          if (cnt_q != 4'd0) begin
            operand_d       = acc_q;
            operand_valid_d = 1'b1;
            acc_d           = '0;
            cnt_d           = 4'd0;
            lcd_rs_d        = 1'b0;
            lcd_data_d      = CMD_CLEAR;
            lcd_req_d       = 1'b1;
            state_d         = ST_LCD_WR;
          end
        end else if (pat_q[1]) begin
          acc_d      = '0;
          cnt_d      = 4'd0;
          lcd_rs_d   = 1'b0;
          lcd_data_d = CMD_CLEAR;
          lcd_req_d  = 1'b1;
          state_d    = ST_LCD_WR;
        end else if (cnt_q < MAX_D) begin
          acc_d      = acc_ext[BIN_W-1:0];
          cnt_d      = cnt_q + 4'd1;
          lcd_rs_d   = 1'b1;
          lcd_data_d = 8'h30 + {4'h0, key_digit};
          lcd_req_d  = 1'b1;
          state_d    = ST_LCD_WR;
        end else begin
          overflow_d = 1'b1;
        end
      end

      ST_LCD_WR: begin
        if (lcd_ack) begin
          lcd_req_d = 1'b0;
          deb_cnt_d = '0;
          state_d   = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (key_valid) begin
          deb_cnt_d = '0;
        end else if (deb_cnt_q >= DEB_CYCLES - 16'd1) begin
          state_d = ST_IDLE;
        end else begin
          deb_cnt_d = deb_inc;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        lcd_req_d = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered outputs; reset overrides everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      pat_q           <= '0;
      deb_cnt_q       <= '0;
      acc_q           <= '0;
      cnt_q           <= 4'd0;
      operand_q       <= '0;
      operand_valid_q <= 1'b0;
      overflow_q      <= 1'b0;
      lcd_req_q       <= 1'b0;
      lcd_rs_q        <= 1'b0;
      lcd_data_q      <= CHR_SPACE;
    end else begin
      state_q         <= state_d;
      pat_q           <= pat_d;
      deb_cnt_q       <= deb_cnt_d;
      acc_q           <= acc_d;
      cnt_q           <= cnt_d;
      operand_q       <= operand_d;
      operand_valid_q <= operand_valid_d;
      overflow_q      <= overflow_d;
      lcd_req_q       <= lcd_req_d;
      lcd_rs_q        <= lcd_rs_d;
      lcd_data_q      <= lcd_data_d;
    end
  end

  // Output mapping
  always_comb begin
    o_lcd_req       = lcd_req_q;
    o_lcd_rs        = lcd_rs_q;
    o_lcd_data      = lcd_data_q;
    o_operand       = operand_q;
    o_operand_valid = operand_valid_q;
    o_digit_cnt     = cnt_q;
    o_overflow      = overflow_q;
    o_busy          = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl with DEB_CYCLES = 4.
module tb_keypad_entry_ctrl;

  localparam logic [15:0] DEB   = 16'd4;
  localparam int          BIN_W = 14;

  logic             clk = 1'b0;
  logic             rst;
  logic [11:0]      i_sw_push;
  logic             lcd_ack;
  logic             o_lcd_req;
  logic             o_lcd_rs;
  logic [7:0]       o_lcd_data;
  logic [BIN_W-1:0] o_operand;
  logic             o_operand_valid;
  logic [3:0]       o_digit_cnt;
  logic             o_overflow;
  logic             o_busy;

  keypad_entry_ctrl #(.DEB_CYCLES(DEB), .MAX_DIGITS(4), .BIN_W(BIN_W)) dut (
    .clk(clk), .rst(rst), .i_sw_push(i_sw_push), .lcd_ack(lcd_ack),
    .o_lcd_req(o_lcd_req), .o_lcd_rs(o_lcd_rs), .o_lcd_data(o_lcd_data),
    .o_operand(o_operand), .o_operand_valid(o_operand_valid),
    .o_digit_cnt(o_digit_cnt), .o_overflow(o_overflow), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: operand built from the digit rules with plain arithmetic
  int m_val, m_cnt, m_last;
  logic [8:0] exp_wr[$];
  logic [8:0] got_wr[$];
  int exp_op[$];
  int got_op[$];
  int exp_ovf, got_ovf;

  bit ack_auto = 1'b0;
  int ack_delay = 0;

  function automatic void model_key(input int idx);
    int d;
    if (idx >= 2) begin
      d = 11 - idx;
      if (m_cnt < 4) begin
        m_val = m_val * 10 + d;
        m_cnt++;
        exp_wr.push_back({1'b1, 8'(48 + d)});
      end else begin
        exp_ovf++;
      end
    end else if (idx == 1) begin
      m_val = 0;
      m_cnt = 0;
      exp_wr.push_back(9'h001);
    end else if (m_cnt > 0) begin
      exp_op.push_back(m_val);
      m_last = m_val;
      m_val = 0;
      m_cnt = 0;
      exp_wr.push_back(9'h001);
    end
  endfunction

  function automatic void clear_logs();
    exp_wr.delete(); got_wr.delete(); exp_op.delete(); got_op.delete();
    exp_ovf = 0; got_ovf = 0;
  endfunction

  // Observer: records each write request, strobe, and checks rs/data hold
  logic       req_prev = 1'b0;
  logic [8:0] held = '0;
  always @(negedge clk) begin
    if (o_lcd_req && !req_prev) got_wr.push_back({o_lcd_rs, o_lcd_data});
    if (o_lcd_req && req_prev) begin
      checks++;
      if ({o_lcd_rs, o_lcd_data} !== held) begin
        errors++;
        $display("FAIL lcd_hold got %h required %h", {o_lcd_rs, o_lcd_data}, held);
      end
    end
    held = {o_lcd_rs, o_lcd_data};
    req_prev = o_lcd_req;
    if (o_operand_valid) got_op.push_back(int'(o_operand));
    if (o_overflow) got_ovf++;
  end

  // Automatic LCD acknowledge responder
  initial begin
    lcd_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_auto && o_lcd_req) begin
        repeat (ack_delay) @(negedge clk);
        lcd_ack = 1'b1;
        @(negedge clk);
        lcd_ack = 1'b0;
      end
    end
  end

  task automatic press_key(input int idx, input int hold);
    int n;
    @(negedge clk);
    i_sw_push = 12'(1) << idx;
    repeat (hold) @(negedge clk);
    i_sw_push = '0;
    n = 0;
    repeat (2) @(negedge clk);
    while ((o_busy || o_lcd_req) && n < 80) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (o_busy || o_lcd_req) begin
      errors++;
      $display("FAIL idle_timeout key %0d busy %0b req %0b", idx, o_busy, o_lcd_req);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_sw_push = '0;
    m_val = 0; m_cnt = 0; m_last = 0;
    clear_logs();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_lcd_req, o_lcd_rs, o_operand_valid, o_overflow, o_busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b required 00000",
               {o_lcd_req, o_lcd_rs, o_operand_valid, o_overflow, o_busy});
    end
    checks++;
    if (o_lcd_data !== 8'h20) begin errors++; $display("FAIL reset_data got %h required 20", o_lcd_data); end
    checks++;
    if (o_digit_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d required 0", o_digit_cnt); end
    checks++;
    if (o_operand !== '0) begin errors++; $display("FAIL reset_operand got %0d required 0", o_operand); end
  endtask

  task automatic test_single_digit();
    int cyc;
    ack_auto = 1'b0;
    clear_logs();
    model_key(4);
    @(negedge clk);
    i_sw_push = 12'h010;
    cyc = 0;
    while (!o_lcd_req && cyc < 20) begin @(negedge clk); cyc++; end
    checks++;
    if (cyc != int'(DEB) + 3) begin errors++; $display("FAIL single_latency got %0d required %0d", cyc, int'(DEB) + 3); end
    checks++;
    if ({o_lcd_req, o_lcd_rs, o_lcd_data} !== {2'b11, 8'h37}) begin
      errors++;
      $display("FAIL single_req got %b/%b/%h required 1/1/37", o_lcd_req, o_lcd_rs, o_lcd_data);
    end
    checks++;
    if (o_digit_cnt !== 4'd1) begin errors++; $display("FAIL single_cnt got %0d required 1", o_digit_cnt); end
    repeat (2) @(negedge clk);
    checks++;
    if (o_lcd_req !== 1'b1) begin errors++; $display("FAIL single_req_wait got %b required 1", o_lcd_req); end
    lcd_ack = 1'b1;
    @(negedge clk);
    lcd_ack = 1'b0;
    checks++;
    if (o_lcd_req !== 1'b0) begin errors++; $display("FAIL single_req_drop got %b required 0", o_lcd_req); end
    i_sw_push = '0;
    repeat (5) @(negedge clk);
    checks++;
    if (o_busy !== 1'b1) begin errors++; $display("FAIL single_release_early got busy %b required 1", o_busy); end
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL single_release_idle got busy %b required 0", o_busy); end
    checks++;
    if (got_wr.size() != exp_wr.size()) begin
      errors++; $display("FAIL single_wr_count got %0d required %0d", got_wr.size(), exp_wr.size());
    end else foreach (exp_wr[i]) begin
      checks++;
      if (got_wr[i] !== exp_wr[i]) begin errors++; $display("FAIL single_wr[%0d] got %h required %h", i, got_wr[i], exp_wr[i]); end
    end
  endtask

  task automatic test_operand_entry();
    int keys[6] = '{1, 10, 9, 8, 7, 0};
    ack_auto = 1'b1; ack_delay = 1;
    clear_logs();
    foreach (keys[k]) begin
      model_key(keys[k]);
      press_key(keys[k], 9);
    end
    checks++;
    if (got_wr.size() != exp_wr.size()) begin
      errors++; $display("FAIL entry_wr_count got %0d required %0d", got_wr.size(), exp_wr.size());
    end else foreach (exp_wr[i]) begin
      checks++;
      if (got_wr[i] !== exp_wr[i]) begin errors++; $display("FAIL entry_wr[%0d] got %h required %h", i, got_wr[i], exp_wr[i]); end
    end
    checks++;
    if (got_op.size() != 1 || exp_op.size() != 1) begin
      errors++; $display("FAIL entry_strobes got %0d required 1", got_op.size());
    end else begin
      checks++;
      if (got_op[0] != exp_op[0]) begin errors++; $display("FAIL entry_operand got %0d required %0d", got_op[0], exp_op[0]); end
    end
    checks++;
    if (int'(o_operand) != 1234) begin errors++; $display("FAIL entry_operand_hold got %0d required 1234", o_operand); end
    checks++;
    if (o_digit_cnt !== 4'd0) begin errors++; $display("FAIL entry_cnt got %0d required 0", o_digit_cnt); end
  endtask

  task automatic test_overflow_clear();
    int keys[4] = '{2, 3, 4, 5};
    int wr_before;
    ack_auto = 1'b1; ack_delay = 0;
    clear_logs();
    foreach (keys[k]) begin model_key(keys[k]); press_key(keys[k], 8); end
    wr_before = got_wr.size();
    model_key(6);
    press_key(6, 10);
    checks++;
    if (got_ovf != exp_ovf) begin errors++; $display("FAIL ovf_count got %0d required %0d", got_ovf, exp_ovf); end
    checks++;
    if (got_wr.size() != wr_before) begin errors++; $display("FAIL ovf_no_write got %0d required %0d", got_wr.size(), wr_before); end
    checks++;
    if (int'(o_digit_cnt) != m_cnt) begin errors++; $display("FAIL ovf_cnt got %0d required %0d", o_digit_cnt, m_cnt); end
    model_key(1); press_key(1, 8);
    checks++;
    if (int'(o_digit_cnt) != m_cnt) begin errors++; $display("FAIL clear_cnt got %0d required %0d", o_digit_cnt, m_cnt); end
    model_key(0); press_key(0, 8);
    checks++;
    if (got_op.size() != exp_op.size()) begin errors++; $display("FAIL empty_enter got %0d strobes required %0d", got_op.size(), exp_op.size()); end
    checks++;
    if (got_wr.size() != exp_wr.size()) begin
      errors++; $display("FAIL ovf_wr_count got %0d required %0d", got_wr.size(), exp_wr.size());
    end else foreach (exp_wr[i]) begin
      checks++;
      if (got_wr[i] !== exp_wr[i]) begin errors++; $display("FAIL ovf_wr[%0d] got %h required %h", i, got_wr[i], exp_wr[i]); end
    end
  endtask

  task automatic test_bounce();
    ack_auto = 1'b1; ack_delay = 2;
    clear_logs();
    for (int t = 0; t < 3; t++) begin
      @(negedge clk); i_sw_push = 12'h100;
      @(negedge clk);
      @(negedge clk); i_sw_push = '0;
      @(negedge clk);
    end
    model_key(8);
    press_key(8, 10);
    checks++;
    if (got_wr.size() != exp_wr.size()) begin
      errors++; $display("FAIL bounce_wr_count got %0d required %0d", got_wr.size(), exp_wr.size());
    end else foreach (exp_wr[i]) begin
      checks++;
      if (got_wr[i] !== exp_wr[i]) begin errors++; $display("FAIL bounce_wr[%0d] got %h required %h", i, got_wr[i], exp_wr[i]); end
    end
    @(negedge clk);
    i_sw_push = 12'h0C0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      checks++;
      if (o_busy !== 1'b0) begin errors++; $display("FAIL multi_key_busy cycle %0d got %b required 0", t, o_busy); end
    end
    i_sw_push = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (got_wr.size() != exp_wr.size()) begin errors++; $display("FAIL multi_key_write got %0d required %0d", got_wr.size(), exp_wr.size()); end
  endtask

  task automatic test_random();
    int r, idx;
    ack_auto = 1'b1;
    clear_logs();
    for (int k = 0; k < 30; k++) begin
      r = $urandom_range(0, 99);
      if (r < 10) idx = 1;
      else if (r < 22) idx = 0;
      else idx = $urandom_range(2, 11);
      ack_delay = $urandom_range(0, 3);
      model_key(idx);
      press_key(idx, $urandom_range(8, 14));
      checks++;
      if (int'(o_digit_cnt) != m_cnt) begin errors++; $display("FAIL rand_cnt step %0d got %0d required %0d", k, o_digit_cnt, m_cnt); end
    end
    checks++;
    if (got_wr.size() != exp_wr.size()) begin
      errors++; $display("FAIL rand_wr_count got %0d required %0d", got_wr.size(), exp_wr.size());
    end else foreach (exp_wr[i]) begin
      checks++;
      if (got_wr[i] !== exp_wr[i]) begin errors++; $display("FAIL rand_wr[%0d] got %h required %h", i, got_wr[i], exp_wr[i]); end
    end
    checks++;
    if (got_op.size() != exp_op.size()) begin
      errors++; $display("FAIL rand_op_count got %0d required %0d", got_op.size(), exp_op.size());
    end else foreach (exp_op[i]) begin
      checks++;
      if (got_op[i] != exp_op[i]) begin errors++; $display("FAIL rand_op[%0d] got %0d required %0d", i, got_op[i], exp_op[i]); end
    end
    checks++;
    if (got_ovf != exp_ovf) begin errors++; $display("FAIL rand_ovf got %0d required %0d", got_ovf, exp_ovf); end
    checks++;
    if (int'(o_operand) != m_last) begin errors++; $display("FAIL rand_operand_hold got %0d required %0d", o_operand, m_last); end
  endtask

  task automatic test_reset_during_req();
    int cyc;
    ack_auto = 1'b0;
    clear_logs();
    model_key(6);
    @(negedge clk);
    i_sw_push = 12'h040;
    cyc = 0;
    while (!o_lcd_req && cyc < 20) begin @(negedge clk); cyc++; end
    checks++;
    if (o_lcd_req !== 1'b1) begin errors++; $display("FAIL rstreq_wait got req %b required 1", o_lcd_req); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    i_sw_push = '0;
    @(negedge clk);
    m_val = 0; m_cnt = 0; m_last = 0;
    rst = 1'b0;
    checks++;
    if ({o_lcd_req, o_busy, o_lcd_rs} !== 3'b000) begin
      errors++; $display("FAIL rstreq_flags got req/busy/rs %b required 000", {o_lcd_req, o_busy, o_lcd_rs});
    end
    checks++;
    if (int'(o_digit_cnt) != m_cnt) begin errors++; $display("FAIL rstreq_cnt got %0d required %0d", o_digit_cnt, m_cnt); end
    checks++;
    if (o_lcd_data !== 8'h20) begin errors++; $display("FAIL rstreq_data got %h required 20", o_lcd_data); end
    lcd_ack = 1'b1;
    repeat (2) @(negedge clk);
    lcd_ack = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({o_lcd_req, o_busy} !== 2'b00) begin errors++; $display("FAIL late_ack got req/busy %b required 00", {o_lcd_req, o_busy}); end
    checks++;
    if (int'(o_operand) != m_last) begin errors++; $display("FAIL rstreq_operand got %0d required %0d", o_operand, m_last); end
    checks++;
    if (got_wr.size() != exp_wr.size()) begin
      errors++; $display("FAIL rstreq_wr_count got %0d required %0d", got_wr.size(), exp_wr.size());
    end else foreach (exp_wr[i]) begin
      checks++;
      if (got_wr[i] !== exp_wr[i]) begin errors++; $display("FAIL rstreq_wr[%0d] got %h required %h", i, got_wr[i], exp_wr[i]); end
    end
  endtask

  initial begin
    rst = 1'b1;
    i_sw_push = '0;
    test_reset();
    test_single_digit();
    test_operand_entry();
    test_overflow_clear();
    test_bounce();
    test_random();
    test_reset_during_req();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
